// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Wide enough for up to four ports; used when picking the winning writer.
  typedef logic [1:0] port_idx_t;

  // Address width for a register count (ceil(log2(n)), at least 1).
  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for RAW hazard detection, with set-over-clear
// priority, per-read-port busy lookup and an any-busy summary.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              any_busy
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [NRD-1:0]   wr_hit;

  // Next pending state: writebacks clear, then a new issue sets (new producer wins).
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) pend_d[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (iss_en) pend_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  // Pending bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Busy lookup; a writeback in flight this cycle hides the pending bit when bypassing.
  always_comb begin
    rd_busy = '0;
    wr_hit  = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int w = 0; w < NWR; w++) begin
        if (BYPASS != 0 && wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) begin
          wr_hit[p] = 1'b1;
        end
      end
      rd_busy[p] = pend_q[rd_addr[p*AW +: AW]] & ~wr_hit[p];
      if (ZERO_REG != 0 && rd_addr[p*AW +: AW] == '0) rd_busy[p] = 1'b0;
    end
  end

  // Summary for stall logic.
  assign any_busy = |pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: storage, prioritised writes, asynchronous
// read ports with optional write bypass, debug read port and scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic                any_busy
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [NRD-1:0]  byp_hit;
  port_idx_t       byp_sel [NRD];

  // Write merge: ports applied in ascending order so the highest index wins.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == '0)) begin
        mem_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes: zero register, then highest-index matching write, then storage.
  always_comb begin
    rd_data = '0;
    byp_hit = '0;
    for (int p = 0; p < NRD; p++) begin
      byp_sel[p] = '0;
      for (int w = 0; w < NWR; w++) begin
        if (BYPASS != 0 && wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) begin
          byp_hit[p] = 1'b1;
          byp_sel[p] = port_idx_t'(w);
        end
      end
      if (ZERO_REG != 0 && rd_addr[p*AW +: AW] == '0) begin
        rd_data[p*XLEN +: XLEN] = '0;
      end else if (byp_hit[p]) begin
        rd_data[p*XLEN +: XLEN] = wr_data[int'(byp_sel[p])*XLEN +: XLEN];
      end else begin
        rd_data[p*XLEN +: XLEN] = mem_q[rd_addr[p*AW +: AW]];
      end
    end
  end

  // Debug port sees stored state only.
  assign dbg_data = (ZERO_REG != 0 && dbg_addr == '0) ? '0 : mem_q[dbg_addr];

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_busy  (rd_busy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing and one non-bypassing instance share
// the same stimulus; directed scenarios plus randomized traffic vs. a model.
module tb_regfile_mp;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int A  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2*A-1:0]  rd_addr = '0;
  logic [1:0]      wr_en = '0;
  logic [2*A-1:0]  wr_addr = '0;
  logic [2*XL-1:0] wr_data = '0;
  logic            iss_en = 1'b0;
  logic [A-1:0]    iss_addr = '0;
  logic [A-1:0]    dbg_addr = '0;

  logic [2*XL-1:0] rdb_data, rdn_data;
  logic [1:0]      rdb_busy, rdn_busy;
  logic [XL-1:0]   dbgb_data, dbgn_data;
  logic            anyb, anyn;

  int checks = 0;
  int errors = 0;

  int unsigned regs_m [NR];
  bit          pend_m [NR];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdb_data), .rd_busy(rdb_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbgb_data), .any_busy(anyb)
  );

  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdn_data), .rd_busy(rdn_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbgn_data), .any_busy(anyn)
  );

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [A-1:0] pick();
    if ($urandom_range(0, 3) == 0) return A'($urandom_range(0, NR - 1));
    return A'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rd_addr = {A'(6), A'(5)};
    dbg_addr = 5;
    #1;
    checks++;
    if (rdb_data !== '0 || rdn_data !== '0 || anyb !== 1'b0 || dbgb_data !== '0) begin
      errors++;
      $display("FAIL reset_initial rd=%h any=%b dbg=%h expected 0", rdb_data, anyb, dbgb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 2'b01; wr_addr[0 +: A] = 5; wr_data[0 +: XL] = 32'hDEAD_BEEF;
    iss_en = 1'b1; iss_addr = 6;
    tick();
    idle();
    #1;
    checks++;
    if (dbgb_data !== 32'hDEAD_BEEF || anyb !== 1'b1) begin
      errors++;
      $display("FAIL reset_prewrite dbg=%h any=%b expected deadbeef/1", dbgb_data, anyb);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rdb_data[0 +: XL] !== '0 || rdn_data[0 +: XL] !== '0 || anyb !== 1'b0 ||
        anyn !== 1'b0 || rdb_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_async rd5=%h/%h any=%b/%b busy=%b expected 0",
               rdb_data[0 +: XL], rdn_data[0 +: XL], anyb, anyn, rdb_busy);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_conflict();
    wr_en = 2'b11;
    wr_addr = {A'(7), A'(7)};
    wr_data = {32'h22, 32'h11};
    rd_addr[0 +: A] = 7;
    #1;
    checks++;
    if (rdb_data[0 +: XL] !== 32'h22 || rdn_data[0 +: XL] !== 32'h0) begin
      errors++;
      $display("FAIL conflict_same_cycle byp=%h nobyp=%h expected 22/0",
               rdb_data[0 +: XL], rdn_data[0 +: XL]);
    end
    tick();
    idle();
    dbg_addr = 7;
    #1;
    checks++;
    if (rdb_data[0 +: XL] !== 32'h22 || rdn_data[0 +: XL] !== 32'h22 ||
        dbgb_data !== 32'h22 || dbgn_data !== 32'h22) begin
      errors++;
      $display("FAIL conflict_after rd=%h/%h dbg=%h/%h expected 22", rdb_data[0 +: XL],
               rdn_data[0 +: XL], dbgb_data, dbgn_data);
    end
  endtask

  task automatic test_bypass();
    wr_en = 2'b01;
    wr_addr[0 +: A] = 3;
    wr_data[0 +: XL] = 32'hABCD;
    rd_addr[A +: A] = 3;
    dbg_addr = 3;
    #1;
    checks++;
    if (rdb_data[XL +: XL] !== 32'hABCD || rdn_data[XL +: XL] !== 32'h0 || dbgb_data !== 32'h0) begin
      errors++;
      $display("FAIL bypass_same_cycle byp=%h nobyp=%h dbg=%h expected abcd/0/0",
               rdb_data[XL +: XL], rdn_data[XL +: XL], dbgb_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdn_data[XL +: XL] !== 32'hABCD || rdb_data[XL +: XL] !== 32'hABCD) begin
      errors++;
      $display("FAIL bypass_next_cycle nobyp=%h byp=%h expected abcd",
               rdn_data[XL +: XL], rdb_data[XL +: XL]);
    end
  endtask

  task automatic test_zero();
    wr_en = 2'b10;
    wr_addr[A +: A] = 0;
    wr_data[XL +: XL] = 32'h5;
    iss_en = 1'b1; iss_addr = 0;
    rd_addr[0 +: A] = 0;
    dbg_addr = 0;
    #1;
    checks++;
    if (rdb_data[0 +: XL] !== '0 || rdb_busy[0] !== 1'b0 || rdn_data[0 +: XL] !== '0) begin
      errors++;
      $display("FAIL zero_same_cycle rd=%h busy=%b expected 0/0", rdb_data[0 +: XL], rdb_busy[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdb_data[0 +: XL] !== '0 || rdn_data[0 +: XL] !== '0 || rdb_busy[0] !== 1'b0 ||
        rdn_busy[0] !== 1'b0 || anyb !== 1'b0 || anyn !== 1'b0 || dbgb_data !== '0) begin
      errors++;
      $display("FAIL zero_after rd=%h busy=%b%b any=%b%b dbg=%h expected 0", rdb_data[0 +: XL],
               rdb_busy[0], rdn_busy[0], anyb, anyn, dbgb_data);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 9;
    rd_addr[0 +: A] = 9;
    #1;
    checks++;
    if (rdb_busy[0] !== 1'b0 || rdn_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_issue_same_cycle busy=%b%b expected 00", rdb_busy[0], rdn_busy[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdb_busy[0] !== 1'b1 || rdn_busy[0] !== 1'b1 || anyb !== 1'b1) begin
      errors++;
      $display("FAIL sb_issued busy=%b%b any=%b expected 1", rdb_busy[0], rdn_busy[0], anyb);
    end
    wr_en = 2'b01; wr_addr[0 +: A] = 9; wr_data[0 +: XL] = 32'h99;
    iss_en = 1'b1; iss_addr = 9;
    #1;
    checks++;
    if (rdb_busy[0] !== 1'b0 || rdn_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_wr_iss_same_cycle busy=%b/%b expected 0/1", rdb_busy[0], rdn_busy[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdb_busy[0] !== 1'b1 || rdn_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins busy=%b%b expected 11", rdb_busy[0], rdn_busy[0]);
    end
    wr_en = 2'b10; wr_addr[A +: A] = 9; wr_data[XL +: XL] = 32'h98;
    #1;
    checks++;
    if (rdb_busy[0] !== 1'b0 || rdn_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_clear_same_cycle busy=%b/%b expected 0/1", rdb_busy[0], rdn_busy[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdb_busy[0] !== 1'b0 || rdn_busy[0] !== 1'b0 || anyb !== 1'b0 || anyn !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared busy=%b%b any=%b%b expected 0", rdb_busy[0], rdn_busy[0],
               anyb, anyn);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [A-1:0]  a, wa;
    logic [XL-1:0] eb, en;
    bit            fwd, exp_any;
    // Start from a known state on both the DUTs and the model.
    idle();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      regs_m[i] = 0;
      pend_m[i] = 1'b0;
    end
    @(negedge clk);
    for (int c = 0; c < cycles && errors < 20; c++) begin
      wr_en = 2'($urandom_range(0, 3));
      for (int w = 0; w < 2; w++) begin
        wr_addr[w*A +: A] = pick();
        wr_data[w*XL +: XL] = $urandom();
      end
      iss_en = ($urandom_range(0, 2) == 0);
      iss_addr = pick();
      for (int p = 0; p < 2; p++) rd_addr[p*A +: A] = pick();
      dbg_addr = pick();
      #1;
      for (int p = 0; p < 2; p++) begin
        a = rd_addr[p*A +: A];
        en = regs_m[a];
        eb = en;
        fwd = 1'b0;
        for (int w = 0; w < 2; w++) begin
          if (wr_en[w] && wr_addr[w*A +: A] == a) begin
            eb = wr_data[w*XL +: XL];
            fwd = 1'b1;
          end
        end
        if (a == 0) begin
          eb = '0;
          en = '0;
        end
        checks++;
        if (rdb_data[p*XL +: XL] !== eb) begin
          errors++;
          $display("FAIL rand_rd_byp c=%0d p=%0d a=%0d got %h want %h", c, p, a,
                   rdb_data[p*XL +: XL], eb);
        end
        checks++;
        if (rdn_data[p*XL +: XL] !== en) begin
          errors++;
          $display("FAIL rand_rd_nobyp c=%0d p=%0d a=%0d got %h want %h", c, p, a,
                   rdn_data[p*XL +: XL], en);
        end
        checks++;
        if (rdb_busy[p] !== (pend_m[a] && !fwd && a != 0)) begin
          errors++;
          $display("FAIL rand_busy_byp c=%0d p=%0d a=%0d got %b want %b", c, p, a, rdb_busy[p],
                   pend_m[a] && !fwd && a != 0);
        end
        checks++;
        if (rdn_busy[p] !== (pend_m[a] && a != 0)) begin
          errors++;
          $display("FAIL rand_busy_nobyp c=%0d p=%0d a=%0d got %b want %b", c, p, a, rdn_busy[p],
                   pend_m[a] && a != 0);
        end
      end
      exp_any = 1'b0;
      for (int i = 0; i < NR; i++) exp_any |= pend_m[i];
      checks++;
      if (anyb !== exp_any || anyn !== exp_any) begin
        errors++;
        $display("FAIL rand_any c=%0d got %b/%b want %b", c, anyb, anyn, exp_any);
      end
      checks++;
      if (dbgb_data !== ((dbg_addr == 0) ? 32'h0 : regs_m[dbg_addr]) || dbgn_data !== dbgb_data) begin
        errors++;
        $display("FAIL rand_dbg c=%0d a=%0d got %h/%h want %h", c, dbg_addr, dbgb_data, dbgn_data,
                 (dbg_addr == 0) ? 32'h0 : regs_m[dbg_addr]);
      end
      // Architectural effect of this cycle's edge.
      for (int w = 0; w < 2; w++) begin
        wa = wr_addr[w*A +: A];
        if (wr_en[w] && wa != 0) regs_m[wa] = wr_data[w*XL +: XL];
        if (wr_en[w]) pend_m[wa] = 1'b0;
      end
      if (iss_en && iss_addr != 0) pend_m[iss_addr] = 1'b1;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_random(10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated scoreboard, for the core's decode/writeback boundary. It provides NRD asynchronous read ports, NWR synchronous write ports with fixed priority, and optional same-cycle write-to-read bypass. A per-register pending bit is set when an instruction with a destination issues and cleared on writeback, so decode can stall on RAW hazards. A debug read port gives the testbench and debug logic access without exposing the storage array.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count; power of two, ≥2
- NRD, 2, read port count, 1..4
- NWR, 2, write port count, 1..2
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never pending
- BYPASS, 1, 1: same-cycle write data and clears forwarded to read ports

Ports (AW = log2(NREGS)):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data per port
- rd_busy  out  NRD  pending bit of the addressed register, per port
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_en  in  1  issue event: mark iss_addr pending
- iss_addr  in  AW  destination of the issuing instruction
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data, never bypassed
- any_busy  out  1  OR of all pending bits

## Operation
- Storage: NREGS×XLEN flops. Pending: NREGS bits.
- Reset (rst_n low, asynchronous): all registers = 0, all pending = 0. The outputs follow combinationally: rd_data = 0, dbg_data = 0, rd_busy = 0, any_busy = 0.
- Write: at each edge, every register addressed by an enabled port takes that port's data.
  - If two ports address the same register, the higher port index wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Pending clear: an enabled write port clears pending[wr_addr] at the edge.
- Pending set: iss_en sets pending[iss_addr] at the edge.
  - If a set and a clear hit the same register in the same cycle, the set wins (new producer).
  - With ZERO_REG=1, iss_addr = 0 is ignored.
- Read, port p:
  - With ZERO_REG=1 and address 0: rd_data = 0, rd_busy = 0.
  - Otherwise, with BYPASS=1, an enabled write to the same address forwards its data combinationally (highest-index matching port wins), and rd_busy = pending AND NOT (matching write this cycle).
  - With BYPASS=0: rd_data = stored value, rd_busy = stored pending bit.
  - Bypass never considers iss_en; rd_busy reflects only pending state before the edge.
- dbg_data = stored value, with address 0 reading 0 when ZERO_REG=1.

## Timing
- Read latency 0; write visible at the read port in the same cycle with BYPASS=1, one cycle after the edge with BYPASS=0.
- Pending set/clear take effect at the edge; rd_busy reflects them from the next cycle.
- Combinational paths: rd_addr/wr_*→rd_data/rd_busy; dbg_addr→dbg_data.
- Reset asserted mid-operation clears state immediately. The first edge after deassertion processes writes and issues normally.

## Structure
- Package regfile_pkg holds:
  - the AW computation as a constant function
  - the XLEN and NREGS defaults
  - a typedef for the port-index type used in the priority resolution
- Sub-module regfile_scoreboard holds the NREGS pending bits, set/clear priority, per-port busy lookup with bypass, and any_busy.
- Top level holds storage, write priority, read muxes and the debug port.

## Test plan
- Reset: write 0xDEAD_BEEF to r5, pulse rst_n low between edges → rd_data for r5 = 0 and any_busy = 0 immediately, without waiting for an edge.
- Write-port conflict: both ports write r7 (port0 0x11, port1 0x22) in one cycle → r7 = 0x22 from the next cycle; dbg_data = 0x22.
- Bypass: BYPASS=1, read r3 while port0 writes 0xABCD to r3 → rd_data = 0xABCD in the same cycle. With BYPASS=0, old value this cycle and 0xABCD next cycle.
- Zero register: write 0x5 to r0, issue r0 → rd_data = 0, rd_busy = 0, any_busy = 0.
- Scoreboard: issue r9 → rd_busy(r9) = 1 next cycle. Write r9 together with iss_en on r9 → r9 stays busy. Write r9 alone → rd_busy(r9) = 0 in that cycle (bypass) and after the edge.
- Random stress: random wr/iss/rd traffic for 10k cycles against a reference model for both BYPASS settings; no mismatch in rd_data or rd_busy.
